uart_rx_param: RTL and testbench

Parametrised UART receiver for the UART top level: configurable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits), internal 16× oversampling with 3-sample majority voting, false-start rejection, break detection, and a small receive FIFO so the consumer can read frames at its own pace. It replaces the fixed 8-bit single-register receive path behind `data_out`/`valid_rx`/`parity_error`/`stop_error`.

---
 rtl/uart_rx_param.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x-style oversampling with 3-sample majority vote,
// false-start rejection, break detection and a small receive FIFO.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          valid_rx,
    output logic                          parity_error,
    output logic                          stop_error,
    output logic                          overflow,
    output logic                          break_detect,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam int M    = OVERSAMPLE / 2;
    localparam int BW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PAR       = 3'd4,
        STOP      = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit: even parity is the XOR of the data, odd its inverse.
    function automatic logic par_calc(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    logic          sync1_r, sync2_r, rxd_s;
    logic [CW-1:0] tick_cnt_r;
    logic          tick_s;

    state_t                 state_r, state_n;
    logic [SW-1:0]          s_r, s_n;
    logic [BW-1:0]          bit_r, bit_n;
    logic [DATA_BITS-1:0]   shreg_r, shreg_n;
    logic                   samp_a_r, samp_a_n, samp_b_r, samp_b_n;
    logic                   par_bit_r, par_bit_n;
    logic                   par_flag_r, par_flag_n;
    logic                   stop_flag_r, stop_flag_n;
    logic                   vote_s, at_vote_s, bit_end_s, in_frame_s, stop_now_s;
    logic                   push_s, brk_s;
    logic [EW-1:0]          push_data_s;

    logic [EW-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic            overflow_r, break_r;
    logic            pop_s, full_s, wr_ok_s, drop_s;
    logic [EW-1:0]   head_s;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
        end
    end
    assign rxd_s = sync2_r;

    // Free-running oversample tick divider
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {CW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end
    assign tick_s = (tick_cnt_r == CW'(DIV - 1));

    assign vote_s     = maj3(samp_a_r, samp_b_r, rxd_s);
    assign at_vote_s  = (s_r == SW'(M + 1));
    assign bit_end_s  = (s_r == SW'(OVERSAMPLE - 1));
    assign in_frame_s = (state_r inside {START, DATA, PAR, STOP});

    // Frame FSM and datapath state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= WAIT_HIGH;
            s_r         <= {SW{1'b0}};
            bit_r       <= {BW{1'b0}};
            shreg_r     <= {DATA_BITS{1'b0}};
            samp_a_r    <= 1'b0;
            samp_b_r    <= 1'b0;
            par_bit_r   <= 1'b0;
            par_flag_r  <= 1'b0;
            stop_flag_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            s_r         <= s_n;
            bit_r       <= bit_n;
            shreg_r     <= shreg_n;
            samp_a_r    <= samp_a_n;
            samp_b_r    <= samp_b_n;
            par_bit_r   <= par_bit_n;
            par_flag_r  <= par_flag_n;
            stop_flag_r <= stop_flag_n;
        end
    end

    // Next-state logic: sample index, majority sampling and per-state frame handling
    always_comb begin
        state_n     = state_r;
        s_n         = s_r;
        bit_n       = bit_r;
        shreg_n     = shreg_r;
        samp_a_n    = samp_a_r;
        samp_b_n    = samp_b_r;
        par_bit_n   = par_bit_r;
        par_flag_n  = par_flag_r;
        stop_flag_n = stop_flag_r;
        stop_now_s  = stop_flag_r | ~vote_s;
        push_s      = 1'b0;
        brk_s       = 1'b0;

        if (tick_s && in_frame_s) begin
            s_n = bit_end_s ? {SW{1'b0}} : s_r + 1'b1;
            if (s_r == SW'(M - 1)) begin
                samp_a_n = rxd_s;
            end else if (s_r == SW'(M)) begin
                samp_b_n = rxd_s;
            end else begin
                samp_a_n = samp_a_r;
            end
        end else begin
            s_n = s_r;
        end

        case (state_r)
            WAIT_HIGH: begin
                if (tick_s && rxd_s) state_n = IDLE;
                else                 state_n = WAIT_HIGH;
            end
            IDLE: begin
                if (tick_s && !rxd_s) begin
                    state_n = START;
                    s_n     = {SW{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (tick_s && at_vote_s && vote_s) begin
                    state_n = IDLE;
                end else if (tick_s && bit_end_s) begin
                    state_n     = DATA;
                    bit_n       = {BW{1'b0}};
                    par_flag_n  = 1'b0;
                    stop_flag_n = 1'b0;
                end else begin
                    state_n = START;
                end
            end
            DATA: begin
                if (tick_s && at_vote_s) begin
                    shreg_n = {vote_s, shreg_r[DATA_BITS-1:1]};
                end else if (tick_s && bit_end_s) begin
                    if (bit_r == BW'(DATA_BITS - 1)) begin
                        state_n = (PARITY != 0) ? PAR : STOP;
                        bit_n   = {BW{1'b0}};
                    end else begin
                        bit_n = bit_r + 1'b1;
                    end
                end else begin
                    state_n = DATA;
                end
            end
            PAR: begin
                if (tick_s && at_vote_s) begin
                    par_bit_n  = vote_s;
                    par_flag_n = (vote_s != par_calc(shreg_r));
                end else if (tick_s && bit_end_s) begin
                    state_n = STOP;
                end else begin
                    state_n = PAR;
                end
            end
            STOP: begin
                if (tick_s && at_vote_s) begin
                    stop_flag_n = stop_now_s;
                    if (bit_r == BW'(STOP_BITS - 1)) begin
                        push_s  = 1'b1;
                        brk_s   = (shreg_r == {DATA_BITS{1'b0}}) &&
                                  ((PARITY == 0) || !par_bit_r) && stop_now_s;
                        state_n = vote_s ? IDLE : WAIT_HIGH;
                    end else begin
                        state_n = STOP;
                    end
                end else if (tick_s && bit_end_s) begin
                    bit_n = bit_r + 1'b1;
                end else begin
                    state_n = STOP;
                end
            end
            default: begin
                state_n = WAIT_HIGH;
            end
        endcase
    end

    assign push_data_s = {shreg_r, par_flag_r, stop_now_s};

    assign pop_s   = rd_en && (count_r != {CNTW{1'b0}});
    assign full_s  = (count_r == CNTW'(FIFO_DEPTH));
    assign wr_ok_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // FIFO storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and break pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CNTW{1'b0}};
            overflow_r <= 1'b0;
            break_r    <= 1'b0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)   rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (drop_s)     overflow_r <= 1'b1;
            else if (pop_s) overflow_r <= 1'b0;
            else            overflow_r <= overflow_r;
            break_r <= brk_s;
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign valid_rx     = (count_r != {CNTW{1'b0}});
    assign data_out     = valid_rx ? head_s[EW-1:2] : {DATA_BITS{1'b0}};
    assign parity_error = valid_rx & head_s[1];
    assign stop_error   = valid_rx & head_s[0];
    assign overflow     = overflow_r;
    assign break_detect = break_r;
    assign fifo_count   = count_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param: an 8E1 instance and a 7O2 instance
// driven with hand-built frames at 8 clocks per oversample tick (128 clocks per bit).
module tb_uart_rx_param;

    localparam int CLK_HZ = 1_228_800;
    localparam int BIT    = 128;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       rxd    = 1'b1;
    logic       rxd2   = 1'b1;
    logic       rd_en  = 1'b0;
    logic       rd_en2 = 1'b0;

    logic [7:0] data_out;
    logic       valid_rx, parity_error, stop_error, overflow, break_detect;
    logic [2:0] fifo_count;
    logic [6:0] data_out2;
    logic       valid_rx2, parity_error2, stop_error2, overflow2, break_detect2;
    logic [2:0] fifo_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cnt;
    int brk_cycles = 0;
    int brk_before;
    event frame_start;

    uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD(9600), .PARITY(1)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en),
        .data_out(data_out), .valid_rx(valid_rx), .parity_error(parity_error),
        .stop_error(stop_error), .overflow(overflow), .break_detect(break_detect),
        .fifo_count(fifo_count)
    );

    uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD(9600), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .rxd(rxd2), .rd_en(rd_en2),
        .data_out(data_out2), .valid_rx(valid_rx2), .parity_error(parity_error2),
        .stop_error(stop_error2), .overflow(overflow2), .break_detect(break_detect2),
        .fifo_count(fifo_count2)
    );

    always #5 clk = ~clk;

    // Reference oversample tick phase: a tick cycle is one with tb_cnt == 7
    always @(posedge clk) begin
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == 7) ? 0 : tb_cnt + 1;
    end

    always @(posedge clk) begin
        if (break_detect === 1'b1) brk_cycles <= brk_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame8(input logic [7:0] d, input logic p, input logic s);
        return {21'd0, s, p, d, 1'b0};
    endfunction

    function automatic logic [31:0] frame7(input logic [6:0] d, input logic p,
                                           input logic s1, input logic s2);
        return {21'd0, s2, s1, p, d, 1'b0};
    endfunction

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd2 = v;
        else     rxd  = v;
    endtask

    // Bits go out LSB first, the start edge aligned so detection lands on a known tick
    task automatic send_bits(input logic [31:0] bits, input int n, input int glitch, input bit sel);
        @(negedge clk);
        while (tb_cnt != 5) @(negedge clk);
        -> frame_start;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BIT; c++) begin
                drive(sel, (i == glitch && c >= 72 && c < 80) ? 1'b0 : bits[i]);
                @(negedge clk);
            end
        end
        drive(sel, 1'b1);
    endtask

    task automatic pop(input bit sel);
        if (sel) rd_en2 = 1'b1;
        else     rd_en  = 1'b1;
        @(negedge clk);
        rd_en  = 1'b0;
        rd_en2 = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 3000 && !valid_rx; i++) @(negedge clk);
        check(tag, valid_rx, 1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_valid", valid_rx, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", data_out, 0);
        check("rst_perr", parity_error, 0);
        check("rst_serr", stop_error, 0);
        check("rst_ovf", overflow, 0);
        check("rst_brk", break_detect, 0);
        reset = 1'b1;
        idle_bits(2);

        // Good 8E1 frame, then a single pop
        send_bits(frame8(8'h3E, 1'b1, 1'b1), 11, -1, 1'b0);
        wait_valid("f3e_valid");
        check("f3e_data", data_out, 8'h3E);
        check("f3e_perr", parity_error, 0);
        check("f3e_serr", stop_error, 0);
        check("f3e_count", fifo_count, 1);
        pop(1'b0);
        check("f3e_pop_count", fifo_count, 0);
        check("f3e_pop_valid", valid_rx, 0);

        // Wrong parity bit
        send_bits(frame8(8'h3E, 1'b0, 1'b1), 11, -1, 1'b0);
        wait_valid("p0_valid");
        check("p0_data", data_out, 8'h3E);
        check("p0_perr", parity_error, 1);
        pop(1'b0);

        // Zero stop bit, line stays low afterwards: must not start another frame
        send_bits({18'd0, 3'b000, 1'b0, 1'b0, 8'h55, 1'b0}, 14, -1, 1'b0);
        idle_bits(12);
        check("s0_count", fifo_count, 1);
        check("s0_data", data_out, 8'h55);
        check("s0_serr", stop_error, 1);
        check("s0_perr", parity_error, 0);
        pop(1'b0);

        // 4-tick low pulse on an idle line is a false start
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        idle_bits(12);
        check("false_start_count", fifo_count, 0);

        // One-tick glitch at the centre sample of data bit 2
        send_bits(frame8(8'hFF, 1'b0, 1'b1), 11, 3, 1'b0);
        wait_valid("glitch_valid");
        check("glitch_data", data_out, 8'hFF);
        check("glitch_perr", parity_error, 0);
        pop(1'b0);

        // Break: line low for two frame times
        brk_before = brk_cycles;
        send_bits(32'd0, 22, -1, 1'b0);
        idle_bits(12);
        check("brk_count", fifo_count, 1);
        check("brk_data", data_out, 0);
        check("brk_serr", stop_error, 1);
        check("brk_perr", parity_error, 0);
        check("brk_pulse_cycles", brk_cycles - brk_before, 1);
        pop(1'b0);
        send_bits(frame8(8'hA5, 1'b0, 1'b1), 11, -1, 1'b0);
        wait_valid("a5_valid");
        check("a5_data", data_out, 8'hA5);
        check("a5_perr", parity_error, 0);
        check("a5_serr", stop_error, 0);
        pop(1'b0);

        // Overflow: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_bits(frame8(8'(i), ^(8'(i)), 1'b1), 11, -1, 1'b0);
        end
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", data_out, 8'h01);
        pop(1'b0);
        check("ovf_cleared", overflow, 0);
        for (int i = 2; i <= 4; i++) begin
            check("ovf_read", data_out, 32'(i));
            pop(1'b0);
        end
        check("ovf_empty", valid_rx, 0);
        pop(1'b0);
        check("empty_pop_count", fifo_count, 0);

        // Push and pop on the same edge while full
        for (int i = 8'h11; i <= 8'h14; i++) begin
            send_bits(frame8(8'(i), ^(8'(i)), 1'b1), 11, -1, 1'b0);
        end
        check("full_count", fifo_count, 4);
        fork
            send_bits(frame8(8'h15, 1'b1, 1'b1), 11, -1, 1'b0);
            begin : rd_side
                int n;
                n = 0;
                @(frame_start);
                while (n < 171) begin
                    @(negedge clk);
                    if (tb_cnt == 7) n++;
                end
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                check("pp_count", fifo_count, 4);
                check("pp_ovf", overflow, 0);
            end
        join
        for (int i = 8'h12; i <= 8'h15; i++) begin
            check("pp_read", data_out, 32'(i));
            pop(1'b0);
        end
        check("pp_empty", fifo_count, 0);

        // Reset mid-frame with the line low, released while low
        send_bits(frame8(8'h77, 1'b0, 1'b1), 11, -1, 1'b0);
        check("pre_rst_count", fifo_count, 1);
        rxd = 1'b0;
        idle_bits(3);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_count", fifo_count, 0);
        check("midrst_valid", valid_rx, 0);
        check("midrst_data", data_out, 0);
        reset = 1'b1;
        idle_bits(4);
        rxd = 1'b1;
        idle_bits(12);
        check("midrst_noframe", fifo_count, 0);
        send_bits(frame8(8'hC3, 1'b0, 1'b1), 11, -1, 1'b0);
        wait_valid("c3_valid");
        check("c3_data", data_out, 8'hC3);
        check("c3_perr", parity_error, 0);
        pop(1'b0);

        // 7O2 instance: good frame, bad parity, second stop bit low
        send_bits(frame7(7'h5A, 1'b1, 1'b1, 1'b1), 11, -1, 1'b1);
        check("o2_count", fifo_count2, 1);
        check("o2_data", data_out2, 7'h5A);
        check("o2_perr", parity_error2, 0);
        check("o2_serr", stop_error2, 0);
        pop(1'b1);
        send_bits(frame7(7'h5A, 1'b0, 1'b1, 1'b1), 11, -1, 1'b1);
        check("o2_bad_perr", parity_error2, 1);
        pop(1'b1);
        send_bits(frame7(7'h2B, 1'b1, 1'b1, 1'b0), 11, -1, 1'b1);
        check("o2_stop2_data", data_out2, 7'h2B);
        check("o2_stop2_serr", stop_error2, 1);
        check("o2_stop2_perr", parity_error2, 0);
        pop(1'b1);
        check("o2_empty", fifo_count2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
